// File: rtl/alu_seq.sv
// Handshaked ALU: captures operands in IDLE, computes in EXEC (or MUL), holds the result in DONE.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier for op 12.
module alu_seq #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_ADDC = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_SLL  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_negative;
    logic             r_carry;
    logic             r_overflow;
    logic             r_illegal;

    logic [SHW-1:0]   w_sh;
    logic             w_cin_eff;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_ill;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [SHW:0]       r_cnt;
    logic [2*WIDTH-1:0] w_prod_next;

    assign w_prod_next = r_prod + (r_b[0] ? r_mcand : '0);
`endif

    assign w_sh      = r_b[SHW-1:0];
    assign w_cin_eff = (r_op == OP_ADDC) & r_cin;
    assign w_sum     = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, w_cin_eff};
    assign w_diff    = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_ill = 1'b0;
        case (r_op)
            OP_AND:  w_res = r_a & r_b;
            OP_OR:   w_res = r_a | r_b;
            OP_XOR:  w_res = r_a ^ r_b;
            OP_NOR:  w_res = ~(r_a | r_b);
            OP_ADD, OP_ADDC: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = ~w_diff[WIDTH];
                w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
            OP_SLL:  w_res = r_a << w_sh;
            OP_SRL:  w_res = r_a >> w_sh;
            OP_SRA:  w_res = $unsigned($signed(r_a) >>> w_sh);
            // MUL never reaches EXEC when the multiplier is built
            OP_MUL:  w_ill = 1'b1;
            default: w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_cin      <= 1'b0;
            r_op       <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_prod     <= '0;
            r_mcand    <= '0;
            r_cnt      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_cin <= cin;
                        r_op  <= op;
`ifdef ALU_SEQ_MUL_EN
                        r_prod  <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, a};
                        r_cnt   <= (SHW+1)'(WIDTH-1);
                        r_state <= (op == OP_MUL) ? S_MUL : S_EXEC;
`else
                        r_state <= S_EXEC;
`endif
                    end
                end
                S_EXEC: begin
                    r_result   <= w_res;
                    r_zero     <= (w_res == '0);
                    r_negative <= w_res[WIDTH-1];
                    r_carry    <= w_c;
                    r_overflow <= w_v;
                    r_illegal  <= w_ill;
                    r_state    <= S_DONE;
                end
                S_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                    // LSB-first: multiplier bits shift out of r_b, multiplicand shifts left
                    r_prod  <= w_prod_next;
                    r_mcand <= r_mcand << 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_result   <= w_prod_next[WIDTH-1:0];
                        r_zero     <= (w_prod_next[WIDTH-1:0] == '0);
                        r_negative <= w_prod_next[WIDTH-1];
                        r_carry    <= |w_prod_next[2*WIDTH-1:WIDTH];
                        r_overflow <= 1'b0;
                        r_illegal  <= 1'b0;
                        r_state    <= S_DONE;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=64): directed corner cases, backpressure, reset, random ops.
// Follows ALU_SEQ_MUL_EN to decide whether op 12 multiplies or is illegal.
module tb_alu_seq;

    localparam int W = 64;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif
    localparam logic signed [64:0] SMAX = 65'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [64:0] SMIN = -65'sh0_8000_0000_0000_0000;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic [3:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          zero;
    logic          negative;
    logic          carry;
    logic          overflow;
    logic          illegal;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
        .illegal(illegal)
    );

    typedef struct packed {
        logic [63:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;
    int   bp_mode = 0;   // 0: always ready, 1: stall, 2: random

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) edges++;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference computed from the opcode definitions with wide arithmetic.
    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                   input logic ci, input logic [3:0] o);
        exp_t e;
        logic [64:0]         s;
        logic signed [64:0]  sx, sy, ss;
        logic [127:0]        p;
        int                  sh;
        e  = '0;
        sh = int'(y % 64);
        sx = $signed({x[63], x});
        sy = $signed({y[63], y});
        e.lat = 2;
        case (o)
            4'd0: e.res = x & y;
            4'd1: e.res = x | y;
            4'd2: e.res = x ^ y;
            4'd3: e.res = ~(x | y);
            4'd4, 4'd6: begin
                s  = {1'b0, x} + {1'b0, y} + ((o == 4'd6 && ci) ? 65'd1 : 65'd0);
                ss = sx + sy + ((o == 4'd6 && ci) ? 65'sd1 : 65'sd0);
                e.res = s[63:0];
                e.c   = s[64];
                e.v   = (ss > SMAX) || (ss < SMIN);
            end
            4'd5: begin
                ss = sx - sy;
                e.res = x - y;
                e.c   = (x >= y);
                e.v   = (ss > SMAX) || (ss < SMIN);
            end
            4'd7:  e.res = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
            4'd8:  e.res = (x < y) ? 64'd1 : 64'd0;
            4'd9:  e.res = x << sh;
            4'd10: e.res = x >> sh;
            4'd11: e.res = $unsigned($signed(x) >>> sh);
            4'd12: begin
                if (MUL_ON) begin
                    p = {64'd0, x} * {64'd0, y};
                    e.res = p[63:0];
                    e.c   = (p[127:64] != 0);
                    e.lat = W + 1;
                end else begin
                    e.ill = 1'b1;
                end
            end
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 0);
        e.n = e.res[63];
        return e;
    endfunction

    // Monitor: pushes expectations on accepted inputs, checks whenever out_valid is presented.
    initial begin
        exp_t e;
        bit   held;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                held = 1'b0;
            end else begin
                if (in_valid && in_ready) begin
                    e     = model(a, b, cin, op);
                    e.acc = edges + 1;
                    sb.push_back(e);
                end
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_out_valid result=%h", result);
                    end else begin
                        e = sb[0];
                        chk(held ? "hold_result" : "result", result, e.res);
                        if (!held) begin
                            chk("zero", 64'(zero), 64'(e.z));
                            chk("negative", 64'(negative), 64'(e.n));
                            chk("carry", 64'(carry), 64'(e.c));
                            chk("overflow", 64'(overflow), 64'(e.v));
                            chk("illegal", 64'(illegal), 64'(e.ill));
                            chk("latency", 64'(edges - e.acc + 1), 64'(e.lat));
                        end
                        chk("in_ready_in_done", 64'(in_ready), 64'd0);
                        held = 1'b1;
                        if (out_ready) begin
                            void'(sb.pop_front());
                            held = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input logic [63:0] ta, input logic [63:0] tbv,
                         input logic tc, input logic [3:0] top);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout in_ready=%b expected=1", in_ready);
        end else begin
            a        = ta;
            b        = tbv;
            cin      = tc;
            op       = top;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || in_ready !== 1'b1) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0 || in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
        end
    endtask

    initial begin
        int seen;
        logic [63:0] ra, rb;
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 64'd5;
        b        = 64'd6;
        cin      = 1'b0;
        op       = 4'd4;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_flags", 64'({zero, negative, carry, overflow, illegal}), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (3) begin
            chk("post_rst_no_capture", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end

        // Directed corners
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4'd4);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4'd4);
        issue(64'd3, 64'd5, 1'b0, 4'd5);
        issue(64'd5, 64'd5, 1'b0, 4'd5);
        issue(64'h8000_0000_0000_0000, 64'd1, 1'b0, 4'd5);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4'd7);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4'd8);
        issue(64'h8000_0000_0000_0000, 64'd63, 1'b0, 4'd11);
        issue(64'h8000_0000_0000_0000, 64'd63, 1'b0, 4'd10);
        issue(64'd1, 64'd64, 1'b0, 4'd9);
        issue(64'hF0F0, 64'h0FF0, 1'b0, 4'd3);
        issue(64'd9, 64'd9, 1'b0, 4'd14);
        issue(64'd9, 64'd9, 1'b0, 4'd12);
        issue(64'h1_0000_0000, 64'h1_0000_0003, 1'b0, 4'd12);
        drain();

        // Backpressure: result held, new input ignored while busy
        bp_mode = 1;
        issue(64'd1, 64'd1, 1'b1, 4'd6);
        a        = 64'd7;
        b        = 64'd7;
        op       = 4'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_result", result, 64'd3);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        bp_mode  = 0;
        @(posedge clk);
        #1;
        chk("bp_released_in_ready", 64'(in_ready), 64'd1);
        chk("bp_pending", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a long MUL (or short illegal op without multiplier)
        issue(64'h1_0000_0000, 64'h1_0000_0003, 1'b0, 4'd12);
        repeat (28) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mul_rst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (70) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        chk("mul_rst_no_out_valid", 64'(seen), 64'd0);

        // Randomized traffic with random backpressure
        bp_mode = 2;
        for (int i = 0; i < 200; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: rb = 64'($urandom_range(0, 130));
                2: ra = {1'b0, ra[62:0]};
                default: ;
            endcase
            issue(ra, rb, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        bp_mode = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 64-bit combinational ALU datapath.
- Registers operands on a valid/ready input handshake and computes one of 13 operations, including shifts, signed and unsigned compare, and add with carry.
- Holds the registered result and NZCV-style flags until the downstream stage accepts them.
- Sits between the register-read stage and writeback in the datapath. An optional iterative multiplier adds a multi-cycle path.

Parameters:
- WIDTH, 64, datapath width. Must be a power of two, 8 or greater.
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands and op are valid
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; b[SHW-1:0] is the shift amount
- cin  in  1  carry-in, used by ADDC only
- op  in  4  opcode
- out_valid  out  1  result and flags are valid
- out_ready  in  1  downstream accepts the result
- result  out  WIDTH  operation result
- zero  out  1  result equals 0
- negative  out  1  result[WIDTH-1]
- carry  out  1  carry or no-borrow (see below)
- overflow  out  1  signed overflow
- illegal  out  1  op was unsupported

Behaviour:
- Reset: state IDLE; result, zero, negative, carry, overflow, illegal all 0; out_valid 0; in_ready 1 in the cycle after reset. Reset mid-operation discards the operation, including an in-flight MUL or an unconsumed DONE result.
- FSM states and transitions:
  - IDLE: in_ready=1. If in_valid is high at an edge, capture a, b, cin, op. Go to MUL if op=12 and MUL is compiled in, else go to EXEC.
  - EXEC: compute, register result and flags, go to DONE. Lasts one cycle.
  - MUL: shift-add loop, one bit per cycle for WIDTH cycles, then register result and flags and go to DONE.
  - DONE: out_valid=1. Outputs are held stable until out_ready=1 at an edge, then go to IDLE.
- in_ready=1 only in IDLE. No back-to-back acceptance in DONE.
- Latency from the accepting edge to out_valid high: 2 cycles for single-cycle ops, WIDTH+1 cycles for MUL.
- In DONE, a and b inputs are ignored and the result is not recomputed.
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 NOR
  - 4 ADD (a+b), 5 SUB (a-b), 6 ADDC (a+b+cin)
  - 7 SLT: signed a<b, result 1 or 0, zero-extended
  - 8 SLTU: unsigned a<b
  - 9 SLL, 10 SRL (logical right), 11 SRA (arithmetic right); shift amount is b[SHW-1:0], so shifts of WIDTH or more wrap modulo WIDTH
  - 12 MUL: low WIDTH bits of the unsigned product
  - 13 to 15: illegal, so result=0, illegal=1, zero=1, and other flags 0
- Flags:
  - zero and negative are derived from the registered result for every op.
  - carry:
    - ADD/ADDC: carry out of bit WIDTH-1.
    - SUB: 1 when a >= b unsigned (no borrow).
    - MUL: 1 when the upper WIDTH bits of the product are nonzero.
    - All other ops: 0.
  - overflow: signed overflow for ADD, ADDC and SUB; 0 otherwise.
- Arithmetic is performed at WIDTH+1 bits internally; the result is truncated to WIDTH.
- Inputs with in_valid low are ignored. in_valid is not required to stay high once accepted.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: the MUL state and iterative multiplier (product and multiplicand shift registers, bit counter of SHW+1 bits) are built, and op 12 behaves as above.
- Undefined: no multiplier logic. Op 12 is treated as illegal: result=0, illegal=1, 2-cycle latency.

Test Plan:
- Reset and idle: assert rst for 2 cycles with in_valid=1 -> out_valid=0, result=0, all flags 0, in_ready=1 the cycle after rst drops, no operation captured.
- Arithmetic, WIDTH=64:
  - ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, zero=1, carry=1, overflow=0, out_valid 2 cycles after accept.
  - ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result=0x8000_0000_0000_0000, negative=1, overflow=1.
- Compare and shifts:
  - SUB a=3, b=5 -> result=0xFFFF_FFFF_FFFF_FFFE, carry=0, negative=1.
  - SLT a=-1, b=1 -> result=1; SLTU with the same operands -> result=0.
  - SRA a=0x8000_0000_0000_0000, b=63 -> all ones.
  - SLL a=1, b=64 -> result=1 (shift-amount wrap).
- Backpressure: ADDC a=1, b=1, cin=1 with out_ready=0 for 5 cycles -> result=3 held stable, out_valid=1, in_ready=0; a new in_valid is not captured; the output is consumed on the first out_ready edge, then in_ready=1.
- MUL with macro defined: a=0x1_0000_0000, b=0x1_0000_0003 -> result=0x3_0000_0000, carry=1, out_valid exactly 65 cycles after accept. Assert rst at cycle 30 -> no out_valid, in_ready=1 next cycle.
- Illegal ops: op=14 (and op=12 with the macro undefined) -> result=0, illegal=1, zero=1, 2-cycle latency.
